cla32_adder_reg: RTL and testbench

- 32-bit binary adder computing {cout, sum} = a + b + cin, with a registered result.
- Sits in the nonpipelined datapath as the ALU add/subtract core; subtract is formed upstream by inverting b and driving cin=1.
- The carry architecture is selectable at elaboration time: ripple-carry, single-level carry-lookahead, or two-level (multilevel) carry-lookahead.
- All architectures are bit-exact equivalent.

---
 rtl/cla32_adder_reg.sv | 94 +++++++++
 tb/tb_cla32_adder_reg.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cla32_adder_reg.sv
// 32-bit adder with registered {cout, sum}; carry network selectable between ripple,
// single-level CLA (4-bit groups, rippled group carries) and two-level CLA.
module cla32_adder_reg #(
  parameter int unsigned ARCH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] s;
  logic [32:0] c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = cin;
  assign s    = p ^ c[31:0];

  if (ARCH == 0) begin : g_ripple
    for (genvar i = 0; i < 32; i++) begin : g_bit
      assign c[i+1] = g[i] | (p[i] & c[i]);
    end
  end else begin : g_cla
    logic [7:0] grp_g;
    logic [7:0] grp_p;

    for (genvar k = 0; k < 8; k++) begin : g_blk
      localparam int unsigned Base = 4 * k;
      logic       ci;
      logic [3:0] bp;
      logic [3:0] bg;

      assign ci = c[Base];
      assign bp = p[Base+3:Base];
      assign bg = g[Base+3:Base];

      assign c[Base+1] = bg[0] | (bp[0] & ci);
      assign c[Base+2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & ci);
      assign c[Base+3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                       | (bp[2] & bp[1] & bp[0] & ci);

      assign grp_g[k] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                      | (bp[3] & bp[2] & bp[1] & bg[0]);
      assign grp_p[k] = &bp;
    end

    if (ARCH == 1) begin : g_single
      // Group carry-out depends on this group's own carry-in: groups ripple.
      for (genvar k = 0; k < 8; k++) begin : g_chain
        assign c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
      end
    end else begin : g_multi
      logic [8:1] grp_c;

      // Each group carry is a sum of products over cin and lower group P/G only,
      // never over another computed group carry.
      always_comb begin
        logic acc;
        logic prod;
        grp_c = '0;
        for (int k = 1; k <= 8; k++) begin
          acc  = 1'b0;
          prod = 1'b1;
          for (int j = k - 1; j >= 0; j--) begin
            acc  = acc | (grp_g[j] & prod);
            prod = prod & grp_p[j];
          end
          grp_c[k] = acc | (prod & cin);
        end
      end

      for (genvar k = 1; k <= 8; k++) begin : g_dist
        assign c[4*k] = grp_c[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= 32'h0;
      cout <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c[32];
    end
  end

endmodule

// File: tb/tb_cla32_adder_reg.sv
// Bench for cla32_adder_reg: all three carry architectures side by side against an
// arithmetic reference, plus directed vectors with literal expectations.
module tb_cla32_adder_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;

  logic [31:0] sum0, sum1, sum2;
  logic        cout0, cout1, cout2;

  logic [32:0] model;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  cla32_adder_reg #(.ARCH(0)) u_arch0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum0), .cout(cout0)
  );
  cla32_adder_reg #(.ARCH(1)) u_arch1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum1), .cout(cout1)
  );
  cla32_adder_reg #(.ARCH(2)) u_arch2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .sum(sum2), .cout(cout2)
  );

  // Reference: a registered 33-bit integer sum with asynchronous clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model <= 33'h0;
    else        model <= {1'b0, a} + {1'b0, b} + {32'h0, cin};
  end

  task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [32:0] want);
    chk({nm, "/model"}, model, want);
    chk({nm, "/arch0"}, {cout0, sum0}, want);
    chk({nm, "/arch1"}, {cout1, sum1}, want);
    chk({nm, "/arch2"}, {cout2, sum2}, want);
  endtask

  task automatic step(input string nm, input logic [31:0] va, input logic [31:0] vb,
                      input logic vc, input logic [32:0] want);
    @(negedge clk);
    a = va;
    b = vb;
    cin = vc;
    @(posedge clk);
    #1;
    chk_all(nm, want);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc/arch0", {cout0, sum0}, model);
      chk("cyc/arch1", {cout1, sum1}, model);
      chk("cyc/arch2", {cout2, sum2}, model);
    end
  end

  initial begin
    a = 32'h12345678;
    b = 32'h1;
    cin = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_all("reset_immediate", 33'h0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all("reset_held", 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("reset_release", {1'b0, 32'h1234567A});

    step("full_propagate", 32'hFFFFFFFF, 32'h0, 1'b1, {1'b1, 32'h00000000});
    step("cin_only_change", 32'hFFFFFFFF, 32'h0, 1'b0, {1'b0, 32'hFFFFFFFF});
    step("max_value", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 32'hFFFFFFFF});
    step("msb_carry", 32'h7FFFFFFF, 32'h1, 1'b0, {1'b0, 32'h80000000});
    step("group0_edge", 32'h0000000F, 32'h1, 1'b0, {1'b0, 32'h00000010});
    step("half_edge", 32'h0000FFFF, 32'h0, 1'b1, {1'b0, 32'h00010000});
    step("nibble_mix", 32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, {1'b1, 32'h00000000});
    step("plain_add", 32'h00001234, 32'h00004321, 1'b1, {1'b0, 32'h00005556});

    // Asynchronous reset pulse entirely between two rising edges.
    @(negedge clk);
    a = 32'h80000000;
    b = 32'h80000000;
    cin = 1'b0;
    @(posedge clk);
    #1 chk_all("pre_pulse", {1'b1, 32'h0});
    step("pre_pulse_nz", 32'h80000001, 32'h80000000, 1'b0, {1'b1, 32'h00000001});
    a = 32'h80000000;
    #1 rst_n = 1'b0;
    #1 chk_all("mid_pulse", 33'h0);
    #1 rst_n = 1'b1;
    #1 chk_all("pulse_released", 33'h0);
    @(posedge clk);
    #1 chk_all("post_pulse", {1'b1, 32'h0});

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      cin = 1'($urandom_range(1, 0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
